fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the control decoder.
- Holds the PC and fetches one 32-bit word per instruction over a req/valid handshake with instruction memory. Latches the word into an instruction register (IR) and splits it into opcode/funct/register/immediate fields for control and the datapath.
- Selects the next PC from PC+4, the J-type target (when control raises jump_en) or a register target (jr_en).

---
 rtl/cpu_pkg.sv | 26 ++
 rtl/fetch_unit_if.sv | 27 ++
 rtl/fetch_next_pc.sv | 40 ++++
 rtl/fetch_unit.sv | 124 ++++++++++++
 tb/tb_fetch_unit.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the fetch stage and its helpers.
//   - PC width and the NOP instruction word
//   - Bit positions of the instruction-register fields
//   - Fetch FSM state type
package cpu_pkg;

    localparam int unsigned PC_W     = 32;
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    // Least-significant bit of each IR field
    localparam int unsigned OPCODE_LSB = 26;  // IR[31:26]
    localparam int unsigned RS_LSB     = 21;  // IR[25:21]
    localparam int unsigned RT_LSB     = 16;  // IR[20:16]
    localparam int unsigned RD_LSB     = 11;  // IR[15:11]
    localparam int unsigned SHAMT_LSB  = 6;   // IR[10:6]
    localparam int unsigned FUNCT_LSB  = 0;   // IR[5:0]
    localparam int unsigned IMM_LSB    = 0;   // IR[15:0]
    localparam int unsigned JTGT_LSB   = 0;   // IR[25:0]

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory fetch handshake.
//   imem_req   : fetch request (fetch -> memory)
//   imem_addr  : byte address of the fetch (fetch -> memory)
//   imem_valid : imem_rdata valid this cycle (memory -> fetch)
//   imem_rdata : fetched instruction word (memory -> fetch)
interface fetch_unit_if;

    logic                     imem_req;
    logic [cpu_pkg::PC_W-1:0] imem_addr;
    logic                     imem_valid;
    logic [31:0]              imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_valid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_valid,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_next_pc.sv
// Next-PC priority mux for the fetch stage (purely combinational).
//   pc_out    : address of the instruction currently in IR
//   jtarget   : IR[25:0] of that instruction
//   jump_en   : J-type redirect (highest priority)
//   jr_en     : register-indirect redirect
//   jr_target : rs value for jr; low two bits are dropped
//   next_pc   : selected next fetch address
//   misalign  : jr selected with a non-word-aligned target
module fetch_next_pc
    import cpu_pkg::*;
#(
    parameter logic [PC_W-1:0] PC_STEP = 32'd4
) (
    input  logic [PC_W-1:0] pc_out,
    input  logic [25:0]     jtarget,
    input  logic            jump_en,
    input  logic            jr_en,
    input  logic [31:0]     jr_target,
    output logic [PC_W-1:0] next_pc,
    output logic            misalign
);

    logic [PC_W-1:0] pc_plus4;
    logic [PC_W-1:0] pc_seq;

    always_comb begin
        pc_plus4 = pc_out + 32'd4;
        pc_seq   = pc_out + PC_STEP;   // wraps modulo 2^32
        next_pc  = pc_seq;
        misalign = 1'b0;
        if (jump_en) begin
            // Region bits come from the address of the following instruction
            next_pc = (pc_plus4 & 32'hF000_0000) | {4'h0, jtarget, 2'b00};
        end else if (jr_en) begin
            next_pc  = {jr_target[31:2], 2'b00};
            misalign = |jr_target[1:0];
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: holds the PC, fetches one word per instruction
// over a req/valid handshake, latches it into IR and splits it into fields.
//   clk, reset   : clock, synchronous active-high reset
//   imem         : fetch handshake (master side)
//   stall        : downstream not ready, hold the current instruction
//   jump_en      : J-type redirect, jr_en/jr_target: register redirect
//   instr_valid  : IR holds a valid instruction
//   opcode..jtarget : IR fields, pc_out: address of the instruction in IR
//   misalign     : one-cycle pulse after a taken jr with a misaligned target
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [PC_W-1:0] PC_STEP  = 32'd4
) (
    input  logic            clk,
    input  logic            reset,
    fetch_unit_if.master    imem,
    input  logic            stall,
    input  logic            jump_en,
    input  logic            jr_en,
    input  logic [31:0]     jr_target,
    output logic            instr_valid,
    output logic [5:0]      opcode,
    output logic [5:0]      funct,
    output logic [4:0]      rs,
    output logic [4:0]      rt,
    output logic [4:0]      rd,
    output logic [4:0]      shamt,
    output logic [15:0]     imm,
    output logic [25:0]     jtarget,
    output logic [PC_W-1:0] pc_out,
    output logic            misalign
);

    fetch_state_t    state, state_d;
    logic [PC_W-1:0] pc;
    logic [31:0]     ir;
    logic            req_d;
    logic            ir_load;
    logic            pc_load;
    logic [PC_W-1:0] next_pc;
    logic            next_misalign;

    fetch_next_pc #(
        .PC_STEP (PC_STEP)
    ) u_next_pc (
        .pc_out    (pc_out),
        .jtarget   (jtarget),
        .jump_en   (jump_en),
        .jr_en     (jr_en),
        .jr_target (jr_target),
        .next_pc   (next_pc),
        .misalign  (next_misalign)
    );

    always_comb begin
        state_d = state;
        req_d   = 1'b0;
        ir_load = 1'b0;
        pc_load = 1'b0;
        unique case (state)
            S_REQ: begin
                req_d   = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                req_d = 1'b1;
                if (imem.imem_valid) begin
                    ir_load = 1'b1;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (!stall) begin
                    pc_load = 1'b1;
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
        // Keep the request low while reset is held, so it first rises once
        // reset has been released.
        if (reset) begin
            req_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_REQ;
            pc          <= RESET_PC;
            ir          <= NOP_WORD;
            pc_out      <= RESET_PC;
            instr_valid <= 1'b0;
            misalign    <= 1'b0;
        end else begin
            state    <= state_d;
            misalign <= pc_load & next_misalign;
            if (ir_load) begin
                ir          <= imem.imem_rdata;
                pc_out      <= pc;
                instr_valid <= 1'b1;
            end
            if (pc_load) begin
                pc          <= next_pc;
                instr_valid <= 1'b0;
            end
        end
    end

    assign imem.imem_req  = req_d;
    assign imem.imem_addr = pc;

    assign opcode  = ir[OPCODE_LSB +: 6];
    assign rs      = ir[RS_LSB     +: 5];
    assign rt      = ir[RT_LSB     +: 5];
    assign rd      = ir[RD_LSB     +: 5];
    assign shamt   = ir[SHAMT_LSB  +: 5];
    assign funct   = ir[FUNCT_LSB  +: 6];
    assign imm     = ir[IMM_LSB    +: 16];
    assign jtarget = ir[JTGT_LSB   +: 26];

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: the bench plays instruction memory
// (lazily randomised word store) and predicts each fetch address from a
// transaction-level model of the next-PC rules.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    localparam int REDIR_SEQ  = 0;
    localparam int REDIR_JUMP = 1;
    localparam int REDIR_JR   = 2;
    localparam int REDIR_BOTH = 3;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        jump_en;
    logic        jr_en;
    logic [31:0] jr_target;
    logic        instr_valid;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [15:0] imm;
    logic [25:0] jtarget;
    logic [31:0] pc_out;
    logic        misalign;

    fetch_unit_if imem_bus ();

    fetch_unit #(
        .RESET_PC (RESET_PC),
        .PC_STEP  (32'd4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem        (imem_bus),
        .stall       (stall),
        .jump_en     (jump_en),
        .jr_en       (jr_en),
        .jr_target   (jr_target),
        .instr_valid (instr_valid),
        .opcode      (opcode),
        .funct       (funct),
        .rs          (rs),
        .rt          (rt),
        .rd          (rd),
        .shamt       (shamt),
        .imm         (imm),
        .jtarget     (jtarget),
        .pc_out      (pc_out),
        .misalign    (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem [logic [31:0]];
    logic [31:0] exp_pc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (!mem.exists(a)) mem[a] = $urandom;
        return mem[a];
    endfunction

    // Entered in the request cycle (just after a falling edge); returns in the
    // request cycle of the following instruction.
    task automatic fetch_one(input int d, input int k, input int redir,
                             input logic [31:0] jrt, input bit spurious);
        logic [31:0] w;
        logic [31:0] nxt;
        logic [31:0] pc4;
        logic        exp_mis;

        stall = 1'b0; jump_en = 1'b0; jr_en = 1'b0;
        check("req_issue",  32'(imem_bus.imem_req), 32'd1);
        check("req_addr",   imem_bus.imem_addr, exp_pc);
        check("req_ivalid", 32'(instr_valid), 32'd0);
        w = mem_word(exp_pc);
        // Data offered during the request cycle must be ignored
        imem_bus.imem_valid = spurious;
        imem_bus.imem_rdata = spurious ? ~w : 32'h0;

        for (int i = 1; i <= d; i++) begin
            @(negedge clk);
            check("wait_req",    32'(imem_bus.imem_req), 32'd1);
            check("wait_addr",   imem_bus.imem_addr, exp_pc);
            check("wait_ivalid", 32'(instr_valid), 32'd0);
            check("wait_mis",    32'(misalign), 32'd0);
            imem_bus.imem_valid = (i == d);
            imem_bus.imem_rdata = (i == d) ? w : $urandom;
        end

        for (int i = 0; i <= k; i++) begin
            @(negedge clk);
            check("hold_ivalid", 32'(instr_valid), 32'd1);
            check("hold_req",    32'(imem_bus.imem_req), 32'd0);
            check("hold_pc",     pc_out, exp_pc);
            check("hold_op_fn",  32'({opcode, funct}), 32'({w[31:26], w[5:0]}));
            check("hold_regs",   32'({rs, rt, rd, shamt}), 32'({w[25:21], w[20:16], w[15:11], w[10:6]}));
            check("hold_imm",    32'(imm), {16'h0, w[15:0]});
            check("hold_jtgt",   32'(jtarget), {6'h0, w[25:0]});
            check("hold_mis",    32'(misalign), 32'd0);
            imem_bus.imem_valid = 1'($urandom_range(0, 1));
            imem_bus.imem_rdata = $urandom;
            if (i < k) begin
                stall     = 1'b1;
                jump_en   = 1'($urandom_range(0, 1));
                jr_en     = 1'($urandom_range(0, 1));
                jr_target = $urandom;
            end else begin
                stall     = 1'b0;
                jump_en   = (redir == REDIR_JUMP) || (redir == REDIR_BOTH);
                jr_en     = (redir == REDIR_JR)   || (redir == REDIR_BOTH);
                jr_target = jrt;
            end
        end

        pc4 = exp_pc + 32'd4;
        exp_mis = 1'b0;
        if (redir == REDIR_JUMP || redir == REDIR_BOTH)
            nxt = {pc4[31:28], w[25:0], 2'b00};
        else if (redir == REDIR_JR) begin
            nxt     = jrt & 32'hFFFF_FFFC;
            exp_mis = (jrt % 4) != 0;
        end else
            nxt = pc4;

        @(negedge clk);
        check("next_ivalid", 32'(instr_valid), 32'd0);
        check("next_mis",    32'(misalign), 32'(exp_mis));
        stall = 1'b0; jump_en = 1'b0; jr_en = 1'b0;
        imem_bus.imem_valid = 1'b0;
        exp_pc = nxt;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; jump_en = 1'b0; jr_en = 1'b0; jr_target = '0;
        imem_bus.imem_valid = 1'b0; imem_bus.imem_rdata = '0;
        mem[32'h0000_0040] = 32'h0800_0010;
        exp_pc = RESET_PC;

        repeat (3) @(negedge clk);
        check("rst_req",    32'(imem_bus.imem_req), 32'd0);
        check("rst_ivalid", 32'(instr_valid), 32'd0);
        check("rst_mis",    32'(misalign), 32'd0);
        check("rst_pcout",  pc_out, RESET_PC);
        check("rst_addr",   imem_bus.imem_addr, RESET_PC);
        check("rst_ir",     32'({opcode, funct, jtarget}), 32'd0);
        reset = 1'b0;
        #1;

        // Sequential at minimum latency, then redirects and boundaries
        fetch_one(1, 0, REDIR_SEQ,  32'h0, 1'b0);
        fetch_one(1, 0, REDIR_SEQ,  32'h0, 1'b0);
        fetch_one(1, 0, REDIR_JR,   32'h0000_0042, 1'b0);
        fetch_one(1, 0, REDIR_JUMP, 32'h0, 1'b0);
        fetch_one(1, 0, REDIR_JR,   32'h0000_1002, 1'b0);
        fetch_one(4, 5, REDIR_SEQ,  32'h0, 1'b0);
        fetch_one(2, 1, REDIR_JR,   32'hFFFF_FFFC, 1'b0);
        fetch_one(1, 0, REDIR_SEQ,  32'h0, 1'b0);
        check("wrap_addr", exp_pc, 32'h0000_0000);
        fetch_one(1, 0, REDIR_BOTH, 32'h0000_1003, 1'b0);

        // Reset while waiting for memory
        check("rw_req", 32'(imem_bus.imem_req), 32'd1);
        @(negedge clk);
        check("rw_wait_req", 32'(imem_bus.imem_req), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("rw_rst_req",    32'(imem_bus.imem_req), 32'd0);
        check("rw_rst_ivalid", 32'(instr_valid), 32'd0);
        check("rw_rst_addr",   imem_bus.imem_addr, RESET_PC);
        check("rw_rst_pcout",  pc_out, RESET_PC);
        @(negedge clk);
        reset  = 1'b0;
        exp_pc = RESET_PC;
        #1;
        fetch_one(3, 0, REDIR_SEQ, 32'h0, 1'b1);

        for (int n = 0; n < 150; n++) begin
            fetch_one($urandom_range(1, 4), $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
